fp_regfile_2r1w: RTL and testbench

FP_REGFILE_2R1W -- requirements
Module: fp_regfile_2r1w

---
 rtl/fp_regfile_2r1w.sv | 122 ++++++++++++
 tb/tb_fp_regfile_2r1w.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_regfile_2r1w.sv
// Two-read / one-write register file for the FP datapath.
// On reset, and whenever a clear is requested, the array is zeroed one word
// per cycle. While that sweep runs the block reports busy and ignores writes
// and reads. Read data is registered, so it appears one cycle after the
// request. RD_MODE chooses what a read returns when it hits the word being
// written in the same cycle: 0 returns the old word, 1 returns the new word.
module fp_regfile_2r1w #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int RD_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  input  logic              clr,
  output logic              busy
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic                r_busy;
  logic [DATA_W-1:0]   r_rdata_a;
  logic [DATA_W-1:0]   r_rdata_b;
  logic                r_rvalid_a;
  logic                r_rvalid_b;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_idle;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_rd_a;
  logic [DATA_W-1:0]   w_rd_b;

  // The single array write port is shared: the sweep owns it while clearing,
  // the user write owns it otherwise.
  always_comb begin
    w_idle      = (r_state == ST_IDLE);
    w_mem_we    = w_idle ? we : 1'b1;
    w_mem_addr  = w_idle ? waddr : r_clr_ptr;
    w_mem_wdata = w_idle ? wdata : '0;
  end

  // Read data selection, including the same-cycle bypass when RD_MODE is 1.
  always_comb begin
    w_rd_a = r_mem[raddr_a];
    w_rd_b = r_mem[raddr_b];
    if ((RD_MODE == 1) && we && (waddr == raddr_a)) w_rd_a = wdata;
    if ((RD_MODE == 1) && we && (waddr == raddr_b)) w_rd_b = wdata;
  end

  // Storage array; deliberately outside the reset domain so only the sweep clears it.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Control FSM: clear sweep, request acceptance and registered read outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_busy     <= 1'b1;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rvalid_a <= 1'b0;
          r_rvalid_b <= 1'b0;
          r_clr_ptr  <= r_clr_ptr + ADDR_W'(1);
          if (r_clr_ptr == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          r_rvalid_a <= re_a;
          r_rvalid_b <= re_b;
          if (re_a) r_rdata_a <= w_rd_a;
          if (re_b) r_rdata_b <= w_rd_b;
          if (clr) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_ptr <= '0;
          r_busy    <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;

endmodule

// File: tb/tb_fp_regfile_2r1w.sv
// Scoreboard bench for fp_regfile_2r1w. Three instances: default geometry in
// read-first and write-first mode sharing one stimulus, plus a small
// 8 x 16-bit read-first instance with its own stimulus.
module tb_fp_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic        we, reA, reB, clr;
  logic [4:0]  waddr, raddrA, raddrB;
  logic [31:0] wdata;

  logic [31:0] rdA0, rdB0, rdA1, rdB1;
  logic        rvA0, rvB0, rvA1, rvB1, busy0, busy1;

  logic        sWe, sReA, sReB, sClr;
  logic [2:0]  sWaddr, sRaddrA, sRaddrB;
  logic [15:0] sWdata;
  logic [15:0] sRdA, sRdB;
  logic        sRvA, sRvB, sBusy;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] qA0[$], qB0[$], qA1[$], qB1[$], qSA[$], qSB[$];

  logic [5:0]  monValid;
  logic [31:0] monData [6];
  string       portName [6] = '{"portA_rdFirst", "portB_rdFirst", "portA_wrFirst",
                                "portB_wrFirst", "portA_small", "portB_small"};

  fp_regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .RD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(reA), .raddr_a(raddrA), .re_b(reB), .raddr_b(raddrB),
    .rdata_a(rdA0), .rdata_b(rdB0), .rvalid_a(rvA0), .rvalid_b(rvB0),
    .clr(clr), .busy(busy0));

  fp_regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .RD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(reA), .raddr_a(raddrA), .re_b(reB), .raddr_b(raddrB),
    .rdata_a(rdA1), .rdata_b(rdB1), .rvalid_a(rvA1), .rvalid_b(rvB1),
    .clr(clr), .busy(busy1));

  fp_regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .RD_MODE(0)) dutSmall (
    .clk(clk), .rst(rst), .we(sWe), .waddr(sWaddr), .wdata(sWdata),
    .re_a(sReA), .raddr_a(sRaddrA), .re_b(sReB), .raddr_b(sRaddrB),
    .rdata_a(sRdA), .rdata_b(sRdB), .rvalid_a(sRvA), .rvalid_b(sRvB),
    .clr(sClr), .busy(sBusy));

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Collect every read port into indexable form for the monitor.
  always_comb begin
    monValid   = {sRvB, sRvA, rvB1, rvA1, rvB0, rvA0};
    monData[0] = rdA0;
    monData[1] = rdB0;
    monData[2] = rdA1;
    monData[3] = rdB1;
    monData[4] = {16'h0000, sRdA};
    monData[5] = {16'h0000, sRdB};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic void pushExp(input int p, input logic [31:0] v);
    case (p)
      0: qA0.push_back(v);
      1: qB0.push_back(v);
      2: qA1.push_back(v);
      3: qB1.push_back(v);
      4: qSA.push_back(v);
      default: qSB.push_back(v);
    endcase
  endfunction

  function automatic int qSize(input int p);
    case (p)
      0: return qA0.size();
      1: return qB0.size();
      2: return qA1.size();
      3: return qB1.size();
      4: return qSA.size();
      default: return qSB.size();
    endcase
  endfunction

  function automatic logic [31:0] popExp(input int p);
    case (p)
      0: return qA0.pop_front();
      1: return qB0.pop_front();
      2: return qA1.pop_front();
      3: return qB1.pop_front();
      4: return qSA.pop_front();
      default: return qSB.pop_front();
    endcase
  endfunction

  // Monitor: every read strobe must match the oldest expectation for its port.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 6; p++) begin
        if (monValid[p]) begin
          if (qSize(p) == 0) begin
            checkCount++;
            $display("[TB] FAIL %s unexpected rvalid: data %h, expected no strobe",
                     portName[p], monData[p]);
          end else begin
            checkOutput(portName[p], monData[p], popExp(p));
          end
        end
      end
    end
  end

  // Drive one cycle of main-instance inputs, then return them to idle.
  task automatic applyStimulus(input logic iWe, input logic [4:0] iWaddr,
                               input logic [31:0] iWdata, input logic iReA,
                               input logic [4:0] iRaA, input logic iReB,
                               input logic [4:0] iRaB, input logic iClr);
    we = iWe; waddr = iWaddr; wdata = iWdata;
    reA = iReA; raddrA = iRaA; reB = iReB; raddrB = iRaB; clr = iClr;
    @(posedge clk);
    #1;
    we = 1'b0; reA = 1'b0; reB = 1'b0; clr = 1'b0;
  endtask

  task automatic applyStimulusSmall(input logic iWe, input logic [3:0] iWaddr,
                                    input logic [15:0] iWdata, input logic iReA,
                                    input logic [2:0] iRaA, input logic iReB,
                                    input logic [2:0] iRaB, input logic iClr);
    sWe = iWe; sWaddr = iWaddr[2:0]; sWdata = iWdata;
    sReA = iReA; sRaddrA = iRaA; sReB = iReB; sRaddrB = iRaB; sClr = iClr;
    @(posedge clk);
    #1;
    sWe = 1'b0; sReA = 1'b0; sReB = 1'b0; sClr = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Count rising edges until the main instance drops busy (bounded).
  task automatic waitSweep(output int edges, output int smallEdges);
    edges = 0;
    smallEdges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (smallEdges == 0 && !sBusy) smallEdges = edges;
      if (!busy0) break;
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus.
  initial begin
    int edges, smallEdges, cnt;
    rst = 1'b1;
    we = 0; reA = 0; reB = 0; clr = 0; waddr = 0; raddrA = 0; raddrB = 0; wdata = 0;
    sWe = 0; sReA = 0; sReB = 0; sClr = 0; sWaddr = 0; sRaddrA = 0; sRaddrB = 0; sWdata = 0;

    #12;
    checkOutput("resetBusy", {31'd0, busy0}, 32'd1);
    checkOutput("resetRdataA", rdA0, 32'h0);
    checkOutput("resetRdataB", rdB1, 32'h0);
    checkOutput("resetRvalid", {30'd0, rvA0, rvB1}, 32'd0);

    @(posedge clk);
    #1 rst = 1'b0;
    waitSweep(edges, smallEdges);
    checkOutput("releaseSweepLen", edges, 32);
    checkOutput("smallSweepLen", smallEdges, 8);
    checkOutput("wrFirstBusyDone", {31'd0, busy1}, 32'd0);

    // Whole array reads back zero after the sweep.
    for (int a = 0; a < 32; a++) begin
      pushExp(0, 32'h0); pushExp(1, 32'h0); pushExp(2, 32'h0); pushExp(3, 32'h0);
      applyStimulus(0, 0, 0, 1, 5'(a), 1, 5'(31 - a), 0);
    end

    // Write then read with one-cycle latency.
    applyStimulus(1, 5'd1, 32'h40C80000, 0, 0, 0, 0, 0);
    pushExp(0, 32'h40C80000); pushExp(2, 32'h40C80000);
    applyStimulus(0, 0, 0, 1, 5'd1, 0, 0, 0);
    checkOutput("readLatencyValid", {31'd0, rvA0}, 32'd1);
    checkOutput("readLatencyData", rdA0, 32'h40C80000);
    idleCycles(1);
    checkOutput("strobeDrops", {31'd0, rvA0}, 32'd0);
    checkOutput("rdataHolds", rdA0, 32'h40C80000);

    // Extreme addresses and both ports on one address.
    applyStimulus(1, 5'd31, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd0, 32'h3F800000, 0, 0, 0, 0, 0);
    pushExp(0, 32'hDEADBEEF); pushExp(1, 32'h3F800000);
    pushExp(2, 32'hDEADBEEF); pushExp(3, 32'h3F800000);
    applyStimulus(0, 0, 0, 1, 5'd31, 1, 5'd0, 0);
    pushExp(0, 32'h40C80000); pushExp(1, 32'h40C80000);
    pushExp(2, 32'h40C80000); pushExp(3, 32'h40C80000);
    applyStimulus(0, 0, 0, 1, 5'd1, 1, 5'd1, 0);

    // Read-during-write collision on address 7.
    applyStimulus(1, 5'd7, 32'hBFC00000, 0, 0, 0, 0, 0);
    pushExp(0, 32'hBFC00000); pushExp(1, 32'hBFC00000);
    pushExp(2, 32'h40980000); pushExp(3, 32'h40980000);
    applyStimulus(1, 5'd7, 32'h40980000, 1, 5'd7, 1, 5'd7, 0);
    pushExp(0, 32'h40980000); pushExp(1, 32'h40980000);
    pushExp(2, 32'h40980000); pushExp(3, 32'h40980000);
    applyStimulus(0, 0, 0, 1, 5'd7, 1, 5'd7, 0);

    // Write to a different address than the read: no bypass in either mode.
    pushExp(0, 32'h0); pushExp(2, 32'h0);
    applyStimulus(1, 5'd8, 32'h11111111, 1, 5'd9, 0, 0, 0);

    // Clear together with a write; requests during the sweep are ignored.
    applyStimulus(1, 5'd10, 32'h40980000, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd3, 32'h12345678, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd3, 32'hCAFEF00D, 0, 0, 0, 0, 1);
    checkOutput("clrBusyRises", {31'd0, busy0}, 32'd1);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 5'd10, 32'hFFFFFFFF, 1, 5'd10, 1, 5'd3, 1);
      if (!busy0) break;
      cnt++;
    end
    checkOutput("clrSweepLen", cnt, 32);
    pushExp(0, 32'h0); pushExp(1, 32'h0); pushExp(2, 32'h0); pushExp(3, 32'h0);
    applyStimulus(0, 0, 0, 1, 5'd3, 1, 5'd10, 0);

    // Reset in the middle of a sweep.
    applyStimulus(1, 5'd5, 32'h41200000, 0, 0, 0, 0, 0);
    pushExp(0, 32'h41200000); pushExp(2, 32'h41200000);
    applyStimulus(0, 0, 0, 1, 5'd5, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    idleCycles(11);
    checkOutput("rdataHoldClear", rdA0, 32'h41200000);
    #2 rst = 1'b1;
    #1;
    checkOutput("midSweepRstBusy", {31'd0, busy0}, 32'd1);
    checkOutput("midSweepRstRdA0", rdA0, 32'h0);
    checkOutput("midSweepRstRdA1", rdA1, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    waitSweep(edges, smallEdges);
    checkOutput("midSweepRestartLen", edges, 32);

    // Reset right after a read strobe appears.
    applyStimulus(1, 5'd6, 32'h3F800000, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd6, 1, 5'd6, 0);
    checkOutput("preRstValid", {31'd0, rvA0}, 32'd1);
    checkOutput("preRstData", rdB1, 32'h3F800000);
    #1 rst = 1'b1;
    #1;
    checkOutput("midReadRstValid", {28'd0, rvA0, rvB0, rvA1, rvB1}, 32'd0);
    checkOutput("midReadRstData", rdB0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    waitSweep(edges, smallEdges);
    checkOutput("midReadRestartLen", edges, 32);

    // Small geometry: address aliasing and 8-cycle clear sweep.
    applyStimulusSmall(1, 4'd9, 16'h1234, 0, 0, 0, 0, 0);
    pushExp(4, 32'h1234); pushExp(5, 32'h0);
    applyStimulusSmall(0, 0, 0, 1, 3'd1, 1, 3'd0, 0);
    pushExp(4, 32'h1234);
    applyStimulusSmall(1, 4'd1, 16'hBEEF, 1, 3'd1, 0, 0, 0);
    pushExp(4, 32'hBEEF); pushExp(5, 32'hBEEF);
    applyStimulusSmall(0, 0, 0, 1, 3'd1, 1, 3'd1, 0);
    applyStimulusSmall(0, 0, 0, 0, 0, 0, 0, 1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      applyStimulusSmall(0, 0, 0, 0, 0, 0, 0, 0);
      if (!sBusy) break;
      cnt++;
    end
    checkOutput("smallClrSweepLen", cnt, 8);
    pushExp(4, 32'h0);
    applyStimulusSmall(0, 0, 0, 1, 3'd1, 0, 0, 0);

    idleCycles(3);
    for (int p = 0; p < 6; p++) begin
      checkOutput({portName[p], "_pendingReads"}, qSize(p), 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
